jtag_ir_dr_chain: RTL and testbench

JTAG_IR_DR_CHAIN -- requirements
Module: jtag_ir_dr_chain

---
 rtl/jtag_ir_dr_chain.sv | 203 ++++++++++++++++++++
 tb/tb_jtag_ir_dr_chain.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_ir_dr_chain.sv
// jtag_ir_dr_chain: JTAG instruction register plus IDCODE / USER / BYPASS
// data registers, driven by externally decoded TAP strobes in the TCK domain.
// Optional USER data register is enabled by defining JTAG_USER_DR_EN; without
// it, code 4'h8 decodes as BYPASS and user_out / user_valid are tied to zero.
module jtag_ir_dr_chain #(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
  parameter int          USER_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tdi,
  input  logic                  capture_ir,
  input  logic                  shift_ir,
  input  logic                  update_ir,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  input  logic [USER_WIDTH-1:0] user_in,
  output logic                  tdo,
  output logic [IR_WIDTH-1:0]   ir_out,
  output logic [USER_WIDTH-1:0] user_out,
  output logic                  user_valid
);

  // Instruction codes, zero-extended to the IR width.
  localparam logic [IR_WIDTH-1:0] C_IDCODE     = IR_WIDTH'(4'h1);
  localparam logic [IR_WIDTH-1:0] C_IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_USER_DR_EN
  localparam logic [IR_WIDTH-1:0] C_USER       = IR_WIDTH'(4'h8);
`endif

  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] r_ir_out;
  logic [31:0]         r_idcode_sr;
  logic                r_bypass;

  logic w_act_cap_ir;
  logic w_act_sh_ir;
  logic w_act_upd_ir;
  logic w_act_cap_dr;
  logic w_act_sh_dr;
  logic w_act_upd_dr;
  logic w_sel_idcode;
  logic w_sel_user;
  logic w_sel_bypass;

  // Strobe arbitration: only the highest-priority strobe acts on an edge.
  always_comb begin
    w_act_cap_ir = 1'b0;
    w_act_sh_ir  = 1'b0;
    w_act_upd_ir = 1'b0;
    w_act_cap_dr = 1'b0;
    w_act_sh_dr  = 1'b0;
    w_act_upd_dr = 1'b0;
    if (capture_ir) begin
      w_act_cap_ir = 1'b1;
    end else if (shift_ir) begin
      w_act_sh_ir = 1'b1;
    end else if (update_ir) begin
      w_act_upd_ir = 1'b1;
    end else if (capture_dr) begin
      w_act_cap_dr = 1'b1;
    end else if (shift_dr) begin
      w_act_sh_dr = 1'b1;
    end else if (update_dr) begin
      w_act_upd_dr = 1'b1;
    end else begin
      w_act_cap_ir = 1'b0;
    end
  end

  // DR selection follows the active instruction, never the IR shift stage.
  always_comb begin
    w_sel_idcode = (r_ir_out == C_IDCODE);
`ifdef JTAG_USER_DR_EN
    w_sel_user   = (r_ir_out == C_USER);
`else
    w_sel_user   = 1'b0;
`endif
    w_sel_bypass = ~w_sel_idcode & ~w_sel_user;
  end

  // IR shift stage: capture the fixed 01 pattern, shift right with tdi into MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir_sr <= '0;
    end else if (w_act_cap_ir) begin
      r_ir_sr <= C_IR_CAPTURE;
    end else if (w_act_sh_ir) begin
      r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
    end else begin
      r_ir_sr <= r_ir_sr;
    end
  end

  // Active instruction: loaded from the shift stage on update_ir.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir_out <= C_IDCODE;
    end else if (w_act_upd_ir) begin
      r_ir_out <= r_ir_sr;
    end else begin
      r_ir_out <= r_ir_out;
    end
  end

  // IDCODE data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idcode_sr <= 32'h0000_0000;
    end else if (w_act_cap_dr && w_sel_idcode) begin
      r_idcode_sr <= IDCODE_VALUE;
    end else if (w_act_sh_dr && w_sel_idcode) begin
      r_idcode_sr <= {tdi, r_idcode_sr[31:1]};
    end else begin
      r_idcode_sr <= r_idcode_sr;
    end
  end

  // Single-bit BYPASS register: captures 0, passes tdi with one edge of delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bypass <= 1'b0;
    end else if (w_act_cap_dr && w_sel_bypass) begin
      r_bypass <= 1'b0;
    end else if (w_act_sh_dr && w_sel_bypass) begin
      r_bypass <= tdi;
    end else begin
      r_bypass <= r_bypass;
    end
  end

`ifdef JTAG_USER_DR_EN
  logic [USER_WIDTH-1:0] r_user_sr;
  logic [USER_WIDTH-1:0] r_user_out;
  logic                  r_user_valid;

  // USER data register: captures fabric value, shifts right with tdi into MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_user_sr <= '0;
    end else if (w_act_cap_dr && w_sel_user) begin
      r_user_sr <= user_in;
    end else if (w_act_sh_dr && w_sel_user) begin
      r_user_sr <= {tdi, r_user_sr[USER_WIDTH-1:1]};
    end else begin
      r_user_sr <= r_user_sr;
    end
  end

  // USER update: latch shifted data and raise a one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_user_out   <= '0;
      r_user_valid <= 1'b0;
    end else if (w_act_upd_dr && w_sel_user) begin
      r_user_out   <= r_user_sr;
      r_user_valid <= 1'b1;
    end else begin
      r_user_out   <= r_user_out;
      r_user_valid <= 1'b0;
    end
  end

  assign user_out   = r_user_out;
  assign user_valid = r_user_valid;

  // Serial output mux: IR stage while shifting IR, otherwise the selected DR.
  always_comb begin
    if (shift_ir) begin
      tdo = r_ir_sr[0];
    end else if (w_sel_idcode) begin
      tdo = r_idcode_sr[0];
    end else if (w_sel_user) begin
      tdo = r_user_sr[0];
    end else begin
      tdo = r_bypass;
    end
  end
`else
  // user_in has no destination when the USER register is absent.
  logic w_unused_user_in;
  assign w_unused_user_in = ^user_in;

  assign user_out   = '0;
  assign user_valid = 1'b0;

  // Serial output mux: IR stage while shifting IR, otherwise the selected DR.
  always_comb begin
    if (shift_ir) begin
      tdo = r_ir_sr[0];
    end else if (w_sel_idcode) begin
      tdo = r_idcode_sr[0];
    end else begin
      tdo = r_bypass;
    end
  end
`endif

  assign ir_out = r_ir_out;

endmodule

// File: tb/tb_jtag_ir_dr_chain.sv
// Scoreboard bench for jtag_ir_dr_chain: stimulus pushes expected values
// tagged with the cycle they must be observed in; a monitor process checks
// them on the falling edge, and separately checks every user_valid pulse.
module tb_jtag_ir_dr_chain;

  localparam int K_TDO = 0;
  localparam int K_IR  = 1;
  localparam int K_UO  = 2;
  localparam int K_UV  = 3;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_CIR  = 6'b100000;
  localparam logic [5:0] S_SIR  = 6'b010000;
  localparam logic [5:0] S_UIR  = 6'b001000;
  localparam logic [5:0] S_CDR  = 6'b000100;
  localparam logic [5:0] S_SDR  = 6'b000010;
  localparam logic [5:0] S_UDR  = 6'b000001;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tdi = 1'b0;
  logic        capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0;
  logic        capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
  logic [31:0] user_in = 32'h0000_0000;
  logic        tdo;
  logic [3:0]  ir_out;
  logic [31:0] user_out;
  logic        user_valid;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          pulses_seen = 0;
  int          pulses_exp = 0;
  exp_t        exp_q[$];
  logic [31:0] uv_q[$];

  jtag_ir_dr_chain #(
    .IR_WIDTH(4), .IDCODE_VALUE(32'h1000_0001), .USER_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .tdi(tdi),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .user_in(user_in), .tdo(tdo), .ir_out(ir_out),
    .user_out(user_out), .user_valid(user_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_TDO:   observe = {31'b0, tdo};
      K_IR:    observe = {28'b0, ir_out};
      K_UO:    observe = user_out;
      K_UV:    observe = {31'b0, user_valid};
      default: observe = 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: expectations due this cycle, plus every user_valid pulse.
  initial forever begin
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc) check({e.name, "_late"}, 32'(cyc), 32'(e.cyc));
      else             check(e.name, observe(e.kind), e.val);
    end
    if (user_valid === 1'b1) begin
      pulses_seen = pulses_seen + 1;
      if (uv_q.size() == 0) check("unexpected_user_valid", 32'd1, 32'd0);
      else                  check("user_out_on_valid", user_out, uv_q.pop_front());
    end
  end

  task automatic expect_now(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] s, input logic d);
    {capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr} = s;
    tdi = d;
  endtask

  task automatic load_ir(input logic [3:0] code);
    set_in(S_CIR, 1'b0); step();
    for (int i = 0; i < 4; i++) begin
      set_in(S_SIR, code[i]); step();
    end
    set_in(S_UIR, 1'b0); step();
    set_in(S_NONE, 1'b0);
  endtask

  task automatic read_dr(input logic [31:0] val, input string name);
    set_in(S_CDR, 1'b0); step();
    for (int i = 0; i < 32; i++) begin
      set_in(S_SDR, 1'b0);
      expect_now(K_TDO, {31'b0, val[i]}, name);
      step();
    end
    set_in(S_NONE, 1'b0);
  endtask

  logic [31:0] uo_keep;
  logic [3:0]  byp_in;
  logic [3:0]  byp_out;

  initial begin
    // Reset state.
    step(); step();
    rst = 1'b0;
    expect_now(K_IR, 32'h1, "reset_ir_out");
    expect_now(K_UO, 32'h0, "reset_user_out");
    expect_now(K_UV, 32'h0, "reset_user_valid");
    expect_now(K_TDO, 32'h0, "reset_tdo");
    step();

    // IDCODE read, LSB first.
    read_dr(32'h1000_0001, "idcode_tdo");

    // IR load of 4'h8; first two tdo bits are the captured 1,0.
    set_in(S_CIR, 1'b0); step();
    set_in(S_SIR, 1'b0); expect_now(K_TDO, 32'h1, "ir_cap_tdo0"); step();
    set_in(S_SIR, 1'b0); expect_now(K_TDO, 32'h0, "ir_cap_tdo1"); step();
    set_in(S_SIR, 1'b0); expect_now(K_IR, 32'h1, "ir_held_while_shift"); step();
    set_in(S_SIR, 1'b1); step();
    set_in(S_UIR, 1'b0); step();
    set_in(S_NONE, 1'b0); expect_now(K_IR, 32'h8, "ir_load_8"); step();

`ifdef JTAG_USER_DR_EN
    // USER write.
    set_in(S_CDR, 1'b0); step();
    for (int i = 0; i < 32; i++) begin
      set_in(S_SDR, 32'hDEAD_BEEF >> i); step();
    end
    set_in(S_UDR, 1'b0); step();
    set_in(S_NONE, 1'b0);
    uv_q.push_back(32'hDEAD_BEEF);
    pulses_exp = pulses_exp + 1;
    expect_now(K_UV, 32'h1, "user_valid_pulse");
    expect_now(K_UO, 32'hDEAD_BEEF, "user_out_write");
    step();
    expect_now(K_UV, 32'h0, "user_valid_one_cycle");
    step();

    // USER read.
    user_in = 32'hA5A5_0F0F;
    read_dr(32'hA5A5_0F0F, "user_tdo");
    user_in = 32'h0000_0000;
    uo_keep = 32'hDEAD_BEEF;
`else
    // Without the USER register, 4'h8 behaves as BYPASS and user_in is ignored.
    user_in = 32'hFFFF_FFFF;
    set_in(S_CDR, 1'b0); step();
    set_in(S_SDR, 1'b1); expect_now(K_TDO, 32'h0, "code8_bypass_tdo0"); step();
    set_in(S_SDR, 1'b0); expect_now(K_TDO, 32'h1, "code8_bypass_tdo1"); step();
    set_in(S_UDR, 1'b0); step();
    set_in(S_NONE, 1'b0);
    expect_now(K_UO, 32'h0, "code8_user_out_zero");
    expect_now(K_UV, 32'h0, "code8_user_valid_zero");
    step();
    user_in = 32'h0000_0000;
    uo_keep = 32'h0000_0000;
`endif

    // BYPASS with code 4'h3: one-edge delay, update_dr has no effect.
    load_ir(4'h3);
    byp_in  = 4'b1101;  // shifted in order bit0..bit3: 1,0,1,1
    byp_out = 4'b1010;  // observed in order bit0..bit3: 0,1,0,1
    set_in(S_CDR, 1'b0); step();
    for (int i = 0; i < 4; i++) begin
      set_in(S_SDR, byp_in[i]);
      expect_now(K_TDO, {31'b0, byp_out[i]}, "bypass_tdo");
      step();
    end
    set_in(S_UDR, 1'b0); step();
    set_in(S_NONE, 1'b0);
    expect_now(K_UO, uo_keep, "bypass_user_out_kept");
    expect_now(K_UV, 32'h0, "bypass_no_valid");
    expect_now(K_TDO, 32'h1, "bypass_holds");
    step();

    // Priority: capture_ir beats capture_dr; shift_ir beats shift_dr.
    set_in(S_CIR | S_CDR, 1'b0); step();
    set_in(S_NONE, 1'b0); expect_now(K_TDO, 32'h1, "prio_capdr_blocked"); step();
    set_in(S_SIR | S_SDR, 1'b0); expect_now(K_TDO, 32'h1, "prio_ir_tdo"); step();
    set_in(S_NONE, 1'b0);
    expect_now(K_TDO, 32'h1, "prio_shdr_blocked");
    expect_now(K_IR, 32'h3, "ir_kept_after_ir_shift");
    step();

    // Reset in the middle of a USER shift, with update_dr on the reset edge.
    load_ir(4'h8);
    set_in(S_CDR, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      set_in(S_SDR, 1'b1); step();
    end
    rst = 1'b1; set_in(S_UDR, 1'b0); step();
    rst = 1'b0; set_in(S_UDR, 1'b0); step();
    set_in(S_NONE, 1'b0);
    expect_now(K_IR, 32'h1, "midrst_ir_out");
    expect_now(K_UO, 32'h0, "midrst_user_out");
    expect_now(K_UV, 32'h0, "midrst_user_valid");
    step();
    expect_now(K_UV, 32'h0, "midrst_user_valid_later");
    step(); step(); step();

    check("expectations_drained", 32'(exp_q.size()), 32'd0);
    check("user_valid_pulse_count", 32'(pulses_seen), 32'(pulses_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
